// File: rtl/pc_redirect_if.sv
// pc_redirect_if: bundles the EX-stage, CSR-side and fetch-side signals of the
// PC sequencer.
//
// Ports (master = pipeline/CSR side that drives requests, slave = sequencer):
//   stall, ex_valid, ex_pc, br_taken, is_jal, is_jalr, opr_res, mret, irq,
//   mtvec, mepc                                  : master -> slave
//   pc, flush, trap_take, trap_pc, in_handler,
//   fsm_state                                    : slave -> master
//
// Handshake: there is no valid/ready pair here. ex_valid is a plain qualifier
// that is sampled every cycle. The EX-side fields are meaningful only when it
// is 1. The sequencer never back-pressures: it acts on every rising edge, and
// it ignores the EX-side fields while fsm_state is TRAP.
interface pc_redirect_if;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        br_taken;
  logic        is_jal;
  logic        is_jalr;
  logic [31:0] opr_res;
  logic        mret;
  logic        irq;
  logic [31:0] mtvec;
  logic [31:0] mepc;

  logic [31:0] pc;
  logic        flush;
  logic        trap_take;
  logic [31:0] trap_pc;
  logic        in_handler;
  logic        fsm_state;   // 0 = RUN, 1 = TRAP

  modport master (
    output stall, ex_valid, ex_pc, br_taken, is_jal, is_jalr, opr_res,
           mret, irq, mtvec, mepc,
    input  pc, flush, trap_take, trap_pc, in_handler, fsm_state
  );

  modport slave (
    input  stall, ex_valid, ex_pc, br_taken, is_jal, is_jalr, opr_res,
           mret, irq, mtvec, mepc,
    output pc, flush, trap_take, trap_pc, in_handler, fsm_state
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: program-counter sequencer for the 5-stage RV32I pipeline.
// It owns the fetch PC. Each cycle the PC advances by 4, holds for a stall, or
// redirects for a branch, a jump, MRET or interrupt entry. The block also
// drives the IF/ID and ID/EX flush and runs the two-state trap entry
// (RUN -> TRAP -> RUN).
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : pc_redirect_if.slave (EX/CSR inputs, pc/flush/trap outputs and
//          the debug FSM state)
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  pc_redirect_if.slave    bus
);

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic        in_handler_q, in_handler_d;
  logic [31:0] seq_next;
  logic        flush;
  logic        trap_take;

  // Address the EX instruction hands control to. When an interrupt is taken
  // instead of the redirect, this becomes the return address.
  always_comb begin
    if (bus.br_taken || bus.is_jal) begin
      seq_next = bus.opr_res;
    end else if (bus.is_jalr) begin
      seq_next = {bus.opr_res[31:1], 1'b0};
    end else begin
      seq_next = bus.ex_pc + 32'd4;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    trap_pc_d    = trap_pc_q;
    in_handler_d = in_handler_q;
    flush        = 1'b0;
    trap_take    = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.ex_valid && bus.mret) begin
          pc_d         = bus.mepc;
          in_handler_d = 1'b0;
          flush        = 1'b1;
        end else if (bus.ex_valid && bus.irq && !in_handler_q) begin
          // The PC is held. The TRAP cycle loads the vector.
          trap_pc_d = seq_next;
          flush     = 1'b1;
          state_d   = TRAP;
        end else if (bus.ex_valid && (bus.br_taken || bus.is_jal)) begin
          pc_d  = bus.opr_res;
          flush = 1'b1;
        end else if (bus.ex_valid && bus.is_jalr) begin
          pc_d  = {bus.opr_res[31:1], 1'b0};
          flush = 1'b1;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      TRAP: begin
        trap_take    = 1'b1;
        flush        = 1'b1;
        pc_d         = {bus.mtvec[31:2], 2'b00};
        in_handler_d = 1'b1;
        state_d      = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // A reset in the TRAP cycle aborts the entry, so the CSR file never sees
    // a pulse.
    if (rst) begin
      flush     = 1'b0;
      trap_take = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      trap_pc_q    <= 32'h0000_0000;
      in_handler_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      trap_pc_q    <= trap_pc_d;
      in_handler_q <= in_handler_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.trap_pc    = trap_pc_q;
  assign bus.in_handler = in_handler_q;
  assign bus.flush      = flush;
  assign bus.trap_take  = trap_take;
  assign bus.fsm_state  = state_q;

endmodule
